// File: rtl/axi_pkg.sv
// Shared AXI encodings, datapath widths and FSM state types for the memory responder.
// Also holds the beat-address and response-priority helpers used by both channel paths.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // WRAP deliberately advances like INCR; it is reported as SLVERR elsewhere.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

  function automatic logic addr_oor(input logic [31:0] addr, input logic [31:0] depth);
    return addr >= (depth << 2);
  endfunction

  function automatic logic [1:0] resp_of(input logic dec, input logic slv);
    return dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// DEPTH x 32 word store: byte-enabled write port, registered read port (1-cycle latency).
// A read and write to the same word in one cycle returns the old word; rd_zero forces 0.
module axi_mem_ram
  import axi_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [STRB_W-1:0]        wr_strb,
  input  logic                     rd_en,
  input  logic                     rd_zero,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  // Contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_zero ? '0 : mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: independent single-outstanding write and read burst FSMs over axi_mem_ram.
// Write: B one cycle after last W; read: beat data one cycle after AR/R handshake; holds payloads under stall.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int ID_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] s_axi_awid,
  input  logic [31:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic [3:0]          s_axi_awcache,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_WIDTH-1:0] s_axi_arid,
  input  logic [31:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic [3:0]          s_axi_arcache,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_WIDTH-1:0] s_axi_rid,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic unused_cache;
  assign unused_cache = ^{s_axi_awcache, s_axi_arcache};

  // Holds both ready outputs low until the first edge after reset release.
  logic init_d, init_q;

  w_state_e            w_state_d, w_state_q;
  logic [ID_WIDTH-1:0] w_id_d, w_id_q;
  logic [31:0]         w_addr_d, w_addr_q;
  logic [7:0]          w_len_d, w_len_q, w_cnt_d, w_cnt_q;
  logic [1:0]          w_burst_d, w_burst_q;
  logic                w_dec_d, w_dec_q, w_slv_d, w_slv_q;
  logic                w_last;

  r_state_e            r_state_d, r_state_q;
  logic [ID_WIDTH-1:0] r_id_d, r_id_q;
  logic [31:0]         r_addr_d, r_addr_q, r_nxt;
  logic [7:0]          r_len_d, r_len_q, r_cnt_d, r_cnt_q;
  logic [1:0]          r_burst_d, r_burst_q;
  logic                r_dec_d, r_dec_q, r_slv_d, r_slv_q;
  logic                r_last;

  logic             ram_wr_en, ram_rd_en, ram_rd_zero;
  logic [IDX_W-1:0] ram_rd_idx;

  assign init_d = 1'b1;
  assign w_last = (w_cnt_q == w_len_q);
  assign r_last = (r_cnt_q == r_len_q);
  assign r_nxt  = next_addr(r_addr_q, r_burst_q);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_dec_d   = w_dec_q;
    w_slv_d   = w_slv_q;
    ram_wr_en = 1'b0;
    case (w_state_q)
      W_IDLE: if (s_axi_awvalid && init_q) begin
        w_state_d = W_DATA;
        w_id_d    = s_axi_awid;
        w_addr_d  = s_axi_awaddr;
        w_len_d   = s_axi_awlen;
        w_cnt_d   = '0;
        w_burst_d = s_axi_awburst;
        w_dec_d   = addr_oor(s_axi_awaddr, DEPTH_W);
        w_slv_d   = (s_axi_awsize != 3'd2) || (s_axi_awburst == BURST_WRAP);
      end
      W_DATA: if (s_axi_wvalid) begin
        ram_wr_en = !addr_oor(w_addr_q, DEPTH_W);
        w_dec_d   = w_dec_q || addr_oor(w_addr_q, DEPTH_W);
        // The beat count, not wlast, ends the burst; a disagreement only taints the response.
        w_slv_d   = w_slv_q || (s_axi_wlast != w_last);
        w_addr_d  = next_addr(w_addr_q, w_burst_q);
        w_cnt_d   = w_cnt_q + 8'd1;
        if (w_last) w_state_d = W_RESP;
      end
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    r_id_d      = r_id_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_burst_d   = r_burst_q;
    r_dec_d     = r_dec_q;
    r_slv_d     = r_slv_q;
    ram_rd_en   = 1'b0;
    ram_rd_zero = 1'b0;
    ram_rd_idx  = r_nxt[2 +: IDX_W];
    if (r_state_q == R_IDLE) begin
      if (s_axi_arvalid && init_q) begin
        r_state_d   = R_DATA;
        r_id_d      = s_axi_arid;
        r_addr_d    = s_axi_araddr;
        r_len_d     = s_axi_arlen;
        r_cnt_d     = '0;
        r_burst_d   = s_axi_arburst;
        r_dec_d     = addr_oor(s_axi_araddr, DEPTH_W);
        r_slv_d     = (s_axi_arsize != 3'd2) || (s_axi_arburst == BURST_WRAP);
        ram_rd_en   = 1'b1;
        ram_rd_zero = addr_oor(s_axi_araddr, DEPTH_W);
        ram_rd_idx  = s_axi_araddr[2 +: IDX_W];
      end
    end else if (s_axi_rready) begin
      if (r_last) begin
        r_state_d = R_IDLE;
      end else begin
        r_addr_d    = r_nxt;
        r_cnt_d     = r_cnt_q + 8'd1;
        r_dec_d     = r_dec_q || addr_oor(r_nxt, DEPTH_W);
        ram_rd_en   = 1'b1;
        ram_rd_zero = addr_oor(r_nxt, DEPTH_W);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q    <= 1'b0;
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_dec_q   <= 1'b0;
      w_slv_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_dec_q   <= 1'b0;
      r_slv_q   <= 1'b0;
    end else begin
      init_q    <= init_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_dec_q   <= w_dec_d;
      w_slv_q   <= w_slv_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
      r_dec_q   <= r_dec_d;
      r_slv_q   <= r_slv_d;
    end
  end

  axi_mem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_wr_en),
    .wr_idx  (w_addr_q[2 +: IDX_W]),
    .wr_data (s_axi_wdata),
    .wr_strb (s_axi_wstrb),
    .rd_en   (ram_rd_en),
    .rd_zero (ram_rd_zero),
    .rd_idx  (ram_rd_idx),
    .rd_data (s_axi_rdata)
  );

  assign s_axi_awready = init_q && (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = resp_of(w_dec_q, w_slv_q);

  assign s_axi_arready = init_q && (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rid     = r_id_q;
  assign s_axi_rresp   = resp_of(r_dec_q, r_slv_q);
  assign s_axi_rlast   = (r_state_q == R_DATA) && r_last;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized scoreboard bench for axi_mem_slave against a word-array reference model.
module tb_axi_mem_slave;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0, s_axi_rdata;
  logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2, s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'b01, s_axi_arburst = 2'b01, s_axi_bresp, s_axi_rresp;
  logic [3:0]  s_axi_awcache = '0, s_axi_arcache = '0, s_axi_wstrb = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_wlast = 1'b0, s_axi_bready = 1'b0;
  logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid;

  axi_mem_slave #(.DEPTH(DEPTH), .ID_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awcache(s_axi_awcache),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] model [DEPTH];
  logic [9:0]  b_exp [$];
  logic [42:0] r_exp [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic oor(input logic [31:0] a);
    return a >= 32'(DEPTH * 4);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  // Monitor: pops expected responses on each handshake and checks payload stability under stall.
  logic        b_hold = 1'b0, r_hold = 1'b0;
  logic [9:0]  b_hold_v = '0;
  logic [42:0] r_hold_v = '0;
  always @(negedge clk) begin
    logic [9:0]  bcur;
    logic [42:0] rcur;
    bcur = {s_axi_bid, s_axi_bresp};
    rcur = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
    if (!rst) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (s_axi_bvalid) begin
        if (b_hold) chk("b_stable", 64'(bcur), 64'(b_hold_v));
        if (s_axi_bready) begin
          b_hold = 1'b0;
          if (b_exp.size() == 0) chk("b_unexpected", 64'(bcur), 64'h1_0000_0000);
          else chk("b_resp", 64'(bcur), 64'(b_exp.pop_front()));
        end else begin
          b_hold = 1'b1;
          b_hold_v = bcur;
        end
      end else b_hold = 1'b0;
      if (s_axi_rvalid) begin
        if (r_hold) chk("r_stable", 64'(rcur), 64'(r_hold_v));
        if (s_axi_rready) begin
          r_hold = 1'b0;
          if (r_exp.size() == 0) chk("r_unexpected", 64'(rcur), 64'h800_0000_0000);
          else chk("r_beat", 64'(rcur), 64'(r_exp.pop_front()));
        end else begin
          r_hold = 1'b1;
          r_hold_v = rcur;
        end
      end else r_hold = 1'b0;
    end
  end

  task automatic wait_hs(input int ch, input string nm);
    int  cnt;
    logic done;
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < 300) begin
      @(negedge clk);
      case (ch)
        0: done = s_axi_awvalid && s_axi_awready;
        1: done = s_axi_wvalid && s_axi_wready;
        2: done = s_axi_bvalid && s_axi_bready;
        default: done = s_axi_arvalid && s_axi_arready;
      endcase
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s: no handshake within %0d cycles", nm, cnt);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    chk("reset_outputs", 64'({s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
                              s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid}), 64'd0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    b_exp.delete();
    r_exp.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("ready_before_edge", 64'({s_axi_awready, s_axi_arready}), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 64'({s_axi_awready, s_axi_arready}), 64'd3);
  endtask

  // Uses wd_q/ws_q as beat data; wlast is driven only on beat wlast_beat.
  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int wlast_beat);
    logic [31:0] a;
    logic dec, slv;
    int nb;
    nb = int'(len) + 1;
    dec = 1'b0;
    slv = (size != 3'd2) || (burst == 2'b10) || (wlast_beat != int'(len));
    for (int i = 0; i < nb; i++) begin
      a = beat_addr(addr, burst, i);
      if (oor(a)) dec = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (ws_q[i][b]) model[int'(a >> 2)][8*b +: 8] = wd_q[i][8*b +: 8];
    end
    b_exp.push_back({id, dec ? 2'b11 : (slv ? 2'b10 : 2'b00)});
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    wait_hs(0, "aw_hs");
    s_axi_awvalid = 1'b0;
    chk("wready_latency", 64'(s_axi_wready), 64'd1);
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axi_wdata = wd_q[i]; s_axi_wstrb = ws_q[i]; s_axi_wlast = (i == wlast_beat);
      s_axi_wvalid = 1'b1;
      wait_hs(1, "w_hs");
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast = 1'b0;
    chk("bvalid_latency", 64'(s_axi_bvalid), 64'd1);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b1;
    wait_hs(2, "b_hs");
    s_axi_bready = 1'b0;
    chk("awready_after_b", 64'(s_axi_awready), 64'd1);
    wd_q.delete();
    ws_q.delete();
  endtask

  // rr_mode: 0 rready high, 1 toggling, 2 random. abort_at >= 0 resets before that beat.
  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int rr_mode, input int abort_at);
    logic [31:0] a;
    logic dec, slv, done;
    int cnt;
    dec = 1'b0;
    slv = (size != 3'd2) || (burst == 2'b10);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      if (oor(a)) dec = 1'b1;
      r_exp.push_back({id, oor(a) ? 32'd0 : model[int'(a >> 2)],
                       dec ? 2'b11 : (slv ? 2'b10 : 2'b00), (i == int'(len))});
    end
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    wait_hs(3, "ar_hs");
    s_axi_arvalid = 1'b0;
    chk("rvalid_latency", 64'(s_axi_rvalid), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == abort_at) begin
        pulse_reset();
        return;
      end
      cnt = 0;
      done = 1'b0;
      while (!done && cnt < 300) begin
        s_axi_rready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? ~s_axi_rready : 1'($urandom_range(0, 1));
        @(negedge clk);
        done = s_axi_rvalid && s_axi_rready;
        @(posedge clk); #1;
        cnt++;
      end
      if (!done) begin
        tests++;
        fails++;
        $display("FAIL r_hs: beat %0d not accepted within %0d cycles", i, cnt);
      end
    end
    s_axi_rready = 1'b0;
    chk("arready_after_rlast", 64'(s_axi_arready), 64'd1);
  endtask

  task automatic push_beats(input int n, input logic [31:0] base, input int rnd);
    for (int i = 0; i < n; i++) begin
      wd_q.push_back(rnd != 0 ? $urandom : base + 32'(i));
      ws_q.push_back(rnd != 0 ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0]  len, id;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [31:0] addr;
    int          sel, wl;
    #2;
    pulse_reset();

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        wd_q.push_back($urandom);
        ws_q.push_back(4'hF);
      end
      do_write(8'(k), 32'(k * 1024), 8'd255, 3'd2, 2'b01, 255);
    end

    push_beats(4, 32'hA0, 0);
    do_write(8'h11, 32'h10, 8'd3, 3'd2, 2'b01, 3);
    do_read(8'h12, 32'h10, 8'd3, 3'd2, 2'b01, 0, -1);

    push_beats(1, 32'hFFFF_FFFF, 0);
    do_write(8'h21, 32'h20, 8'd0, 3'd2, 2'b01, 0);
    wd_q.push_back(32'h1234_5678);
    ws_q.push_back(4'b0101);
    do_write(8'h22, 32'h20, 8'd0, 3'd2, 2'b01, 0);
    do_read(8'h23, 32'h20, 8'd0, 3'd2, 2'b01, 0, -1);

    push_beats(3, 32'd1, 0);
    do_write(8'h31, 32'h40, 8'd2, 3'd2, 2'b00, 2);
    do_read(8'h32, 32'h40, 8'd0, 3'd2, 2'b01, 0, -1);

    do_read(8'h41, 32'h1000, 8'd1, 3'd2, 2'b01, 0, -1);
    push_beats(1, 32'hDEAD_BEEF, 0);
    do_write(8'h42, 32'h1000, 8'd0, 3'd2, 2'b01, 0);
    do_read(8'h43, 32'h0, 8'd0, 3'd2, 2'b01, 0, -1);

    push_beats(2, 32'h5150, 0);
    do_write(8'h51, 32'h80, 8'd1, 3'd2, 2'b01, 0);
    do_read(8'h52, 32'h80, 8'd1, 3'd2, 2'b01, 0, -1);
    do_read(8'h53, 32'h80, 8'd1, 3'd1, 2'b01, 0, -1);

    do_read(8'h61, 32'h200, 8'd7, 3'd2, 2'b01, 1, 3);
    do_read(8'h62, 32'h200, 8'd7, 3'd2, 2'b01, 1, -1);

    for (int t = 0; t < 40; t++) begin
      len = 8'($urandom_range(0, 15));
      id = 8'($urandom);
      sel = int'($urandom_range(0, 9));
      burst = (sel < 2) ? 2'b00 : (sel < 9) ? 2'b01 : 2'b10;
      size = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 9) == 0) addr = 32'((DEPTH + int'($urandom_range(0, 50))) * 4);
      else addr = 32'(int'($urandom_range(0, DEPTH - 1 - int'(len))) * 4);
      sel = int'($urandom_range(0, 9));
      wl = (sel == 0) ? int'($urandom_range(0, int'(len))) : (sel == 1) ? int'(len) + 1 : int'(len);
      push_beats(int'(len) + 1, 32'd0, 1);
      do_write(id, addr, len, size, burst, wl);
      do_read(id ^ 8'h5A, addr, len, ($urandom_range(0, 7) == 0) ? 3'd0 : 3'd2,
              burst, int'($urandom_range(0, 2)), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("b_queue_drained", 64'(b_exp.size()), 64'd0);
    chk("r_queue_drained", 64'(r_exp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 responder with on-chip memory that terminates the `m_axi_*` side of `axi_fifo`. It accepts AW/W bursts and AR bursts, stores and returns 32-bit words with byte strobes, and generates B and R responses. It is the memory endpoint for bench and system use, replacing ad-hoc memory models hung off the master ports.

## Interface
Parameters:
- `DEPTH`, 1024: memory depth in 32-bit words; must be a power of two.
- `ID_WIDTH`, 8: AXI ID width.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `s_axi_awid` input ID_WIDTH, `s_axi_awaddr` input 32, `s_axi_awlen` input 8, `s_axi_awsize` input 3, `s_axi_awburst` input 2, `s_axi_awcache` input 4 (ignored), `s_axi_awvalid` input 1, `s_axi_awready` output 1: write address channel.
- `s_axi_wdata` input 32, `s_axi_wstrb` input 4, `s_axi_wlast` input 1, `s_axi_wvalid` input 1, `s_axi_wready` output 1: write data channel.
- `s_axi_bid` output ID_WIDTH, `s_axi_bresp` output 2, `s_axi_bvalid` output 1, `s_axi_bready` input 1: write response channel.
- `s_axi_arid` input ID_WIDTH, `s_axi_araddr` input 32, `s_axi_arlen` input 8, `s_axi_arsize` input 3, `s_axi_arburst` input 2, `s_axi_arcache` input 4 (ignored), `s_axi_arvalid` input 1, `s_axi_arready` output 1: read address channel.
- `s_axi_rid` output ID_WIDTH, `s_axi_rdata` output 32, `s_axi_rresp` output 2, `s_axi_rlast` output 1, `s_axi_rvalid` output 1, `s_axi_rready` input 1: read data channel.

## Operation
- Read and write paths are independent FSMs. Each path has one outstanding burst and no interleaving.
- Word index is `addr[2 +: log2(DEPTH)]`. An address is out of range if `addr[31:2] >= DEPTH`.
- Beat address update: FIXED keeps the address. INCR adds 4. WRAP is handled as INCR and flagged SLVERR. 4 KB boundary crossing is not checked.
- Response priority per burst:
  - DECERR (2'b11) if the start address or any beat address is out of range.
  - Otherwise SLVERR (2'b10) if size != 2, burst is WRAP, or there is a wlast mismatch (write path only).
  - Otherwise OKAY.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. The AW handshake latches id, address, len, burst and error flags.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb to the current word, unless that word is out of range. After awlen+1 beats, go to W_RESP.
  - wlast mismatch: wlast asserted early, or absent on the final beat. Beat count still governs termination.
  - W_RESP: bvalid=1, bid=latched id. Leave on the bready handshake.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. The AR handshake latches the request and loads the rdata register from the start word.
  - R_DATA: rvalid=1 with rid, rresp and rlast (rlast on beat arlen+1). Each R handshake reloads rdata from the next beat address.
  - Out-of-range beats return rdata=0 with DECERR on every beat.
  - Leave R_DATA after the rlast handshake.
- Same-word conflict: when an rdata load and a W write hit the same word in the same cycle, rdata gets the old data (read-before-write).
- Reset: all FSMs return to IDLE and any in-flight burst is dropped without a response. Memory contents are not cleared.
- Reset values: every output is 0.

## Timing
- awready and arready rise on the first clk edge after rst deasserts.
- Write: AW handshake at cycle N, wready=1 from N+1. Final W handshake at M, bvalid=1 from M+1. B handshake at K, awready=1 from K+1.
- Single-beat write minimum turnaround is 3 cycles.
- Read: AR handshake at N, rvalid with beat-0 data at N+1. Each subsequent beat is valid the cycle after the previous handshake, so full throughput is 1 beat/cycle with rready held high. Last handshake at K, arready=1 from K+1.
- bvalid, rvalid and their payloads stay stable until the handshake.
- AW and AR may be accepted in the same cycle.

## Structure
- Package `axi_pkg`:
  - burst encodings FIXED/INCR/WRAP;
  - resp codes OKAY/EXOKAY/SLVERR/DECERR;
  - data width 32 and strobe width 4;
  - FSM state enums.
- Sub-module `axi_mem_ram`: DEPTH x 32 array, one byte-enable write port, one synchronous read port with read-before-write.

## Test plan
- INCR write at 0x10, len=3, data 0xA0..0xA3, wstrb=0xF, then INCR read at 0x10, len=3 -> B OKAY with matching bid; R returns A0..A3, rlast on beat 4, OKAY.
- Write 0xFFFFFFFF to 0x20, then write 0x12345678 with wstrb=4'b0101, then read 0x20 -> 0xFF34FF78.
- FIXED write at 0x40, len=2, data 1,2,3, then read 0x40 -> 0x00000003.
- Read at 0x1000 (word 1024, DEPTH=1024), len=1 -> two beats, rdata 0, rresp DECERR. Write to the same address -> bresp DECERR and memory unchanged.
- Write len=1 with wlast on beat 0 -> bresp SLVERR and both beats written. Read with arsize=1 -> rresp SLVERR.
- rready toggling 1/0 on a len=7 read, with rst pulsed low mid-burst -> data held stable while stalled. After reset: all outputs 0, arready=1 one cycle later, and previously written data is intact on re-read.
